// File: rtl/picomem_sram_arbiter.sv
// Two-master to one-slave arbiter for the PicoMem native memory bus.
// Registered owner state, combinational request/response muxing, per-grant watchdog.
module picomem_sram_arbiter #(
    parameter int          ARB_MODE       = 0,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               own0, own1;
    logic [1:0]         own;
    logic               cur_valid, done_ok, expire, win_m1;
    logic [31:0]        rsp_data;
    logic [1:0]         rsp;
    logic [31:0]        rsp_rdata [2];

    assign own = state_q;

    always_comb begin
        own0      = (state_q == OWN0);
        own1      = (state_q == OWN1);
        cur_valid = (own0 && m0_valid) || (own1 && m1_valid);
        done_ok   = cur_valid && s_ready;
        // A slave ready on the expiry cycle still counts as a normal completion.
        expire    = WDOG_EN && cur_valid && !s_ready && (cnt_q == CNT_LIMIT);
        s_valid   = cur_valid && !expire;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        if (own0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (own1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
        rsp_data = expire ? TIMEOUT_RDATA : s_rdata;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp[gi]       = own[gi] && (done_ok || expire);
        assign rsp_rdata[gi] = rsp[gi] ? rsp_data : 32'd0;
    end

    assign m0_ready = rsp[0];
    assign m1_ready = rsp[1];
    assign m0_rdata = rsp_rdata[0];
    assign m1_rdata = rsp_rdata[1];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        win_m1  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    win_m1 = (ARB_MODE == 0) ? !last_q : 1'b0;
                end else begin
                    win_m1 = m1_valid;
                end
                if (m0_valid || m1_valid) begin
                    state_d = win_m1 ? OWN1 : OWN0;
                    last_d  = win_m1;
                    cnt_d   = '0;
                end
            end
            OWN0, OWN1: begin
                // Completion, timeout or an abandoned request all return to IDLE,
                // which forces the idle gap the slave needs between transfers.
                if (!cur_valid || done_ok || expire) begin
                    state_d = IDLE;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (expire) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign grant       = state_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_picomem_sram_arbiter.sv
// Bench for picomem_sram_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against an owner/wait-count reference model.
module tb_picomem_sram_arbiter;
    localparam int          TMO     = 8;
    localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid, s_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready, s_valid, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    logic        fp_m0_valid, fp_m1_valid, fp_s_ready;
    logic [31:0] fp_s_rdata;
    logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_timeout_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;
    logic [1:0]  fp_grant;

    always #5 clk = ~clk;

    picomem_sram_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TMO), .TIMEOUT_RDATA(TO_DATA)) u_dut (
        .clk(clk), .reset(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    picomem_sram_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(0), .TIMEOUT_RDATA(TO_DATA)) u_fp (
        .clk(clk), .reset(rst),
        .m0_valid(fp_m0_valid), .m0_addr(32'h0000_0500), .m0_wdata(32'd0), .m0_wstrb(4'd0),
        .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_valid(fp_m1_valid), .m1_addr(32'h0000_0600), .m1_wdata(32'h1111_2222), .m1_wstrb(4'hF),
        .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .s_valid(fp_s_valid), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
        .s_ready(fp_s_ready), .s_rdata(fp_s_rdata),
        .grant(fp_grant), .timeout_err(fp_timeout_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, how many owned cycles have passed, who won last.
    int mdl_own  = -1;
    int mdl_wait = 0;
    int mdl_last = 1;
    bit mdl_err  = 1'b0;

    logic        r0_seen, r1_seen, sv_seen, err_seen;
    logic [31:0] rd0_seen, rd1_seen, sa_seen, sw_seen;
    logic [3:0]  st_seen;
    logic [1:0]  g_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_own  = -1;
        mdl_wait = 0;
        mdl_last = 1;
        mdl_err  = 1'b0;
    endtask

    // Called at a negedge with inputs already applied; checks, advances the model,
    // and returns at the next negedge.
    task automatic cycle();
        bit          mv, done, tmo, e_r0, e_r1;
        logic [31:0] e_addr, e_wdata, e_grant;
        logic [3:0]  e_wstrb;
        #1;
        mv      = (mdl_own == 0) ? m0_valid : (mdl_own == 1) ? m1_valid : 1'b0;
        done    = (mdl_own >= 0) && mv && s_ready;
        tmo     = (mdl_own >= 0) && mv && !s_ready && (mdl_wait == TMO);
        e_r0    = (mdl_own == 0) && (done || tmo);
        e_r1    = (mdl_own == 1) && (done || tmo);
        e_addr  = (mdl_own == 0) ? m0_addr  : (mdl_own == 1) ? m1_addr  : 32'd0;
        e_wdata = (mdl_own == 0) ? m0_wdata : (mdl_own == 1) ? m1_wdata : 32'd0;
        e_wstrb = (mdl_own == 0) ? m0_wstrb : (mdl_own == 1) ? m1_wstrb : 4'd0;
        e_grant = (mdl_own < 0) ? 32'd0 : ((mdl_own == 0) ? 32'd1 : 32'd2);
        chk("grant", {30'd0, grant}, e_grant);
        chk("s_valid", {31'd0, s_valid}, {31'd0, mv && !tmo});
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_wdata);
        chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, e_wstrb});
        chk("m0_ready", {31'd0, m0_ready}, {31'd0, e_r0});
        chk("m1_ready", {31'd0, m1_ready}, {31'd0, e_r1});
        if (e_r0) chk("m0_rdata", m0_rdata, tmo ? TO_DATA : s_rdata);
        else if (mdl_own != 0) chk("m0_rdata_ungranted", m0_rdata, 32'd0);
        if (e_r1) chk("m1_rdata", m1_rdata, tmo ? TO_DATA : s_rdata);
        else if (mdl_own != 1) chk("m1_rdata_ungranted", m1_rdata, 32'd0);
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, mdl_err});
        r0_seen = m0_ready;  r1_seen = m1_ready;  rd0_seen = m0_rdata; rd1_seen = m1_rdata;
        sv_seen = s_valid;   g_seen = grant;      sa_seen = s_addr;    sw_seen = s_wdata;
        st_seen = s_wstrb;   err_seen = timeout_err;
        if (mdl_own < 0) begin
            if (m0_valid || m1_valid) begin
                mdl_own  = (m0_valid && m1_valid) ? (1 - mdl_last) : (m1_valid ? 1 : 0);
                mdl_last = mdl_own;
                mdl_wait = 0;
            end
        end else if (!mv || done || tmo) begin
            if (tmo) mdl_err = 1'b1;
            mdl_own = -1;
        end else begin
            mdl_wait++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int order[$];
        int rem0, rem1;
        bit sv_prev, sr_prev, act0, act1;
        int p;

        rst = 1'b0;
        idle_inputs();
        fp_m0_valid = 1'b0; fp_m1_valid = 1'b0; fp_s_ready = 1'b0; fp_s_rdata = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_fp_grant", {30'd0, fp_grant}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();

        // Fixed priority: both masters request 4 times, m0 must take all of its turns first.
        rem0 = 4; rem1 = 4; sv_prev = 1'b0; sr_prev = 1'b0;
        for (int k = 0; k < 200 && (rem0 > 0 || rem1 > 0); k++) begin
            fp_m0_valid = (rem0 > 0);
            fp_m1_valid = (rem1 > 0);
            fp_s_ready  = sv_prev && !sr_prev;
            fp_s_rdata  = 32'(k);
            #1;
            if (fp_m0_ready) begin order.push_back(0); rem0--; chk("fp_m0_rdata", fp_m0_rdata, 32'(k)); end
            if (fp_m1_ready) begin order.push_back(1); rem1--; chk("fp_m1_rdata", fp_m1_rdata, 32'(k)); end
            sv_prev = fp_s_valid;
            sr_prev = fp_s_ready;
            @(negedge clk);
        end
        chk("fp_count", 32'(order.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("fp_order", (k < order.size()) ? 32'(order[k]) : 32'd9, (k < 4) ? 32'd0 : 32'd1);
        // Watchdog disabled: a hung request is never completed.
        fp_m1_valid = 1'b1; fp_s_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            #1;
            chk("fp_no_timeout_ready", {31'd0, fp_m1_ready}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("fp_no_timeout_err", {31'd0, fp_timeout_err}, 32'd0);
        fp_m1_valid = 1'b0;
        @(negedge clk);

        // m0 read, slave ready one cycle after s_valid.
        m0_valid = 1'b1; m0_addr = 32'h100;
        cycle();
        chk("t1_n_grant", {30'd0, g_seen}, 32'd0);
        chk("t1_n_svalid", {31'd0, sv_seen}, 32'd0);
        cycle();
        chk("t1_n1_grant", {30'd0, g_seen}, 32'd1);
        chk("t1_n1_svalid", {31'd0, sv_seen}, 32'd1);
        chk("t1_n1_addr", sa_seen, 32'h100);
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        cycle();
        chk("t1_n2_ready", {31'd0, r0_seen}, 32'd1);
        chk("t1_n2_rdata", rd0_seen, 32'h1234_5678);
        m0_valid = 1'b0; s_ready = 1'b0;
        cycle();
        chk("t1_n3_grant", {30'd0, g_seen}, 32'd0);
        chk("t1_n3_svalid", {31'd0, sv_seen}, 32'd0);

        // m1 write passes through unchanged while m0 waits.
        m1_valid = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hA5A5_5A5A; m1_wstrb = 4'b0011;
        cycle();
        m0_valid = 1'b1; m0_addr = 32'h200;
        cycle();
        chk("t3_grant", {30'd0, g_seen}, 32'd2);
        chk("t3_addr", sa_seen, 32'h10);
        chk("t3_wdata", sw_seen, 32'hA5A5_5A5A);
        chk("t3_wstrb", {28'd0, st_seen}, 32'd3);
        chk("t3_m0_held", {31'd0, r0_seen}, 32'd0);
        cycle();
        s_ready = 1'b1;
        cycle();
        chk("t3_m1_ready", {31'd0, r1_seen}, 32'd1);
        chk("t3_m0_still_held", {31'd0, r0_seen}, 32'd0);
        m1_valid = 1'b0; s_ready = 1'b0;
        cycle();
        chk("t3_gap_grant", {30'd0, g_seen}, 32'd0);
        cycle();
        chk("t3_m0_grant", {30'd0, g_seen}, 32'd1);
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        cycle();
        chk("t3_m0_rdata", rd0_seen, 32'hCAFE_F00D);
        m0_valid = 1'b0; s_ready = 1'b0;
        cycle();

        // Slave ready lands exactly on the expiry cycle: normal completion wins.
        m0_valid = 1'b1; m0_addr = 32'h300;
        cycle();
        for (int k = 0; k < TMO; k++) begin
            cycle();
            chk("t5_wait_ready", {31'd0, r0_seen}, 32'd0);
        end
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        cycle();
        chk("t5_ready", {31'd0, r0_seen}, 32'd1);
        chk("t5_rdata", rd0_seen, 32'h0BAD_F00D);
        m0_valid = 1'b0; s_ready = 1'b0;
        cycle();
        chk("t5_err_clear", {31'd0, err_seen}, 32'd0);

        // Slave never readies: watchdog completes m0, then m1 is served.
        m0_valid = 1'b1; m0_addr = 32'h304;
        cycle();
        m1_valid = 1'b1; m1_addr = 32'h44; m1_wstrb = 4'd0;
        for (int k = 0; k < TMO; k++) begin
            cycle();
            chk("t4_wait_ready", {31'd0, r0_seen}, 32'd0);
        end
        cycle();
        chk("t4_ready", {31'd0, r0_seen}, 32'd1);
        chk("t4_rdata", rd0_seen, TO_DATA);
        chk("t4_svalid_forced", {31'd0, sv_seen}, 32'd0);
        m0_valid = 1'b0;
        cycle();
        chk("t4_err_set", {31'd0, err_seen}, 32'd1);
        cycle();
        chk("t4_m1_grant", {30'd0, g_seen}, 32'd2);
        s_ready = 1'b1; s_rdata = 32'h55;
        cycle();
        chk("t4_m1_rdata", rd1_seen, 32'h55);
        m1_valid = 1'b0; s_ready = 1'b0;
        cycle();

        // Randomized traffic with varying slave responsiveness.
        act0 = 1'b0; act1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            p = ((i / 500) % 3 == 0) ? 50 : (((i / 500) % 3 == 1) ? 12 : 0);
            if (r0_seen) act0 = 1'b0;
            else if (act0 && $urandom_range(0, 63) == 0) act0 = 1'b0;
            if (!act0 && $urandom_range(0, 3) == 0) begin
                act0 = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom_range(0, 15));
            end
            if (r1_seen) act1 = 1'b0;
            else if (act1 && $urandom_range(0, 63) == 0) act1 = 1'b0;
            if (!act1 && $urandom_range(0, 3) == 0) begin
                act1 = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom_range(0, 15));
            end
            m0_valid = act0;
            m1_valid = act1;
            s_ready  = ($urandom_range(0, 99) < p);
            s_rdata  = $urandom;
            cycle();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();

        // Reset while m1 owns the bus, then round-robin with both masters requesting.
        m1_valid = 1'b1; m1_addr = 32'h80;
        cycle();
        s_ready = 1'b1; s_rdata = 32'h77;
        #1;
        chk("t6_pre_svalid", {31'd0, s_valid}, 32'd1);
        chk("t6_pre_grant", {30'd0, grant}, 32'd2);
        rst = 1'b1;
        #1;
        chk("t6_svalid_drop", {31'd0, s_valid}, 32'd0);
        chk("t6_grant_drop", {30'd0, grant}, 32'd0);
        chk("t6_m1_ready_drop", {31'd0, m1_ready}, 32'd0);
        chk("t6_err_cleared", {31'd0, timeout_err}, 32'd0);
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_ready = 1'b0;

        order.delete();
        rem0 = 4; rem1 = 4; sv_prev = 1'b0; sr_prev = 1'b0;
        m0_addr = 32'h400; m0_wstrb = 4'd0; m1_addr = 32'h500; m1_wdata = 32'h9999_0000; m1_wstrb = 4'hF;
        for (int k = 0; k < 200 && (rem0 > 0 || rem1 > 0); k++) begin
            m0_valid = (rem0 > 0);
            m1_valid = (rem1 > 0);
            s_ready  = sv_prev && !sr_prev;
            s_rdata  = 32'(k);
            cycle();
            sv_prev = sv_seen;
            sr_prev = s_ready;
            if (r0_seen) begin order.push_back(0); rem0--; end
            if (r1_seen) begin order.push_back(1); rem1--; end
        end
        chk("rr_count", 32'(order.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("rr_order", (k < order.size()) ? 32'(order[k]) : 32'd9, 32'(k % 2));
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
